ex_div_ctrl: RTL and testbench

- EX-stage sequencer for the iterative divider: accepts a DIV/DIVU request from EX and drives the divider's start/annul/operand inputs.
- Stalls the pipeline while the division runs, captures the 64-bit result and issues a one-cycle HI/LO write.
- Sits between EX decode and the divider; its outputs merge into EX's stallreq and HI/LO write path.

---
 rtl/ex_div_ctrl_pkg.sv | 18 +
 rtl/ex_div_ctrl.sv | 133 +++++++++++++
 tb/tb_ex_div_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_ctrl_pkg.sv
// Shared constants and state encoding for the EX-stage divide sequencer.
// Imported by ex_div_ctrl; holds the divider handshake levels and FSM states.
package ex_div_ctrl_pkg;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/ex_div_ctrl.sv
// EX-stage sequencer for the iterative divider: latches operands, stalls the
// pipeline while the divider runs, and issues a one-cycle HI/LO write.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MAX_CYCLES = 40
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                div_req_i,
  input  logic                div_signed_i,
  input  logic [DATA_W-1:0]   op1_i,
  input  logic [DATA_W-1:0]   op2_i,
  input  logic                flush_i,
  input  logic [2*DATA_W-1:0] div_result_i,
  input  logic                div_ready_i,
  output logic [DATA_W-1:0]   div_opdata1_o,
  output logic [DATA_W-1:0]   div_opdata2_o,
  output logic                div_signed_o,
  output logic                div_start_o,
  output logic                div_annul_o,
  output logic                stallreq_o,
  output logic                whilo_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                timeout_o
);

  localparam int              CNT_W    = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  div_state_e        state_reg, state_next;
  logic [DATA_W-1:0] opdata1_reg, opdata2_reg;
  logic              signed_reg;
  logic [DATA_W-1:0] hi_reg, lo_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              timeout_reg;

  logic              latch_ops;
  logic              capture;
  logic              set_timeout;
  logic              start;
  logic              annul;
  logic              stall;
  logic              whilo;

  always_comb begin
    state_next  = state_reg;
    latch_ops   = 1'b0;
    capture     = 1'b0;
    set_timeout = 1'b0;
    start       = DIV_STOP;
    annul       = 1'b0;
    stall       = 1'b0;
    whilo       = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (div_req_i && !flush_i) begin
          stall      = 1'b1;
          latch_ops  = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = !flush_i;
        start = DIV_START;
        // Flush beats a coincident ready; a late ready still beats the watchdog.
        if (flush_i) begin
          annul      = 1'b1;
          start      = DIV_STOP;
          state_next = ST_IDLE;
        end else if (div_ready_i == DIV_RESULT_READY) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end else if (cnt_reg == CNT_LAST) begin
          annul       = 1'b1;
          start       = DIV_STOP;
          set_timeout = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_DONE: begin
        whilo      = !flush_i;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      opdata1_reg <= '0;
      opdata2_reg <= '0;
      signed_reg  <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (latch_ops) begin
        opdata1_reg <= op1_i;
        opdata2_reg <= op2_i;
        signed_reg  <= div_signed_i;
        cnt_reg     <= '0;
      end else if (state_reg == ST_BUSY) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (capture) begin
        hi_reg <= div_result_i[2*DATA_W-1:DATA_W];
        lo_reg <= div_result_i[DATA_W-1:0];
      end
      if (set_timeout) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign div_opdata1_o = opdata1_reg;
  assign div_opdata2_o = opdata2_reg;
  assign div_signed_o  = signed_reg;
  assign div_start_o   = start;
  assign div_annul_o   = annul;
  assign stallreq_o    = stall;
  assign whilo_o       = whilo;
  assign hi_o          = hi_reg;
  assign lo_o          = lo_reg;
  assign timeout_o     = timeout_reg;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Transaction-level bench for ex_div_ctrl: the bench plays EX and the divider,
// and predicts each divide's timeline and result from plain arithmetic.
module tb_ex_div_ctrl;

  localparam int DATA_W     = 32;
  localparam int MAX_CYCLES = 40;

  logic                clk = 1'b0;
  logic                rst;
  logic                div_req_i;
  logic                div_signed_i;
  logic [DATA_W-1:0]   op1_i;
  logic [DATA_W-1:0]   op2_i;
  logic                flush_i;
  logic [2*DATA_W-1:0] div_result_i;
  logic                div_ready_i;
  logic [DATA_W-1:0]   div_opdata1_o;
  logic [DATA_W-1:0]   div_opdata2_o;
  logic                div_signed_o;
  logic                div_start_o;
  logic                div_annul_o;
  logic                stallreq_o;
  logic                whilo_o;
  logic [DATA_W-1:0]   hi_o;
  logic [DATA_W-1:0]   lo_o;
  logic                timeout_o;

  ex_div_ctrl #(.DATA_W(DATA_W), .MAX_CYCLES(MAX_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_req_i    (div_req_i),
    .div_signed_i (div_signed_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .flush_i      (flush_i),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .div_opdata1_o(div_opdata1_o),
    .div_opdata2_o(div_opdata2_o),
    .div_signed_o (div_signed_o),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .stallreq_o   (stallreq_o),
    .whilo_o      (whilo_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] exp_hi = '0;
  logic [DATA_W-1:0] exp_lo = '0;
  logic              exp_to = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference divider: {remainder, quotient}; zero divisor yields zero.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'd0, a}) / longint'({32'd0, b});
      r = longint'({32'd0, a}) % longint'({32'd0, b});
    end
    return {r[31:0], q[31:0]};
  endfunction

  // One idle cycle; only legal when the request must not be accepted.
  task automatic idle_cycle(input logic req, input logic fl);
    @(negedge clk);
    div_req_i    = req;
    flush_i      = fl;
    div_ready_i  = 1'b0;
    op1_i        = $urandom;
    op2_i        = $urandom;
    div_result_i = {$urandom, $urandom};
    #1;
    check("idle_stall", 64'(stallreq_o), 64'(req & ~fl));
    check("idle_start", 64'(div_start_o), 64'd0);
    check("idle_whilo", 64'(whilo_o), 64'd0);
    check("idle_hi", 64'(hi_o), 64'(exp_hi));
    check("idle_lo", 64'(lo_o), 64'(exp_lo));
    check("idle_timeout", 64'(timeout_o), 64'(exp_to));
  endtask

  // lat: BUSY cycle where the divider reports ready (0 = never).
  // fl_cyc: BUSY cycle with a flush (0 = none). done_fl: flush during DONE.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int fl_cyc, input logic done_fl);
    logic [63:0] res;
    logic        fl, rd, abort;
    bit          finished;
    int          k;
    res = ref_div(sgn, a, b);
    @(negedge clk);
    div_req_i    = 1'b1;
    div_signed_i = sgn;
    op1_i        = a;
    op2_i        = b;
    flush_i      = 1'b0;
    div_ready_i  = 1'b0;
    div_result_i = {$urandom, $urandom};
    #1;
    check("req_stall", 64'(stallreq_o), 64'd1);
    check("req_start", 64'(div_start_o), 64'd0);
    check("req_whilo", 64'(whilo_o), 64'd0);
    check("req_hold_hi", 64'(hi_o), 64'(exp_hi));
    check("req_hold_lo", 64'(lo_o), 64'(exp_lo));
    check("req_timeout", 64'(timeout_o), 64'(exp_to));

    finished = 0;
    rd       = 1'b0;
    k        = 1;
    while (!finished && k <= MAX_CYCLES) begin
      @(negedge clk);
      fl           = (k == fl_cyc);
      rd           = (k == lat);
      div_req_i    = 1'b1;
      op1_i        = $urandom;
      op2_i        = $urandom;
      div_signed_i = $urandom;
      flush_i      = fl;
      div_ready_i  = rd;
      div_result_i = rd ? res : {$urandom, $urandom};
      #1;
      abort = fl || (!rd && k == MAX_CYCLES);
      check("busy_start", 64'(div_start_o), 64'(!abort));
      check("busy_annul", 64'(div_annul_o), 64'(abort));
      check("busy_stall", 64'(stallreq_o), 64'(!fl));
      check("busy_op1", 64'(div_opdata1_o), 64'(a));
      check("busy_op2", 64'(div_opdata2_o), 64'(b));
      check("busy_signed", 64'(div_signed_o), 64'(sgn));
      check("busy_whilo", 64'(whilo_o), 64'd0);
      if (abort && !fl) exp_to = 1'b1;
      if (abort) rd = 1'b0;
      finished = abort || rd;
      k++;
    end

    if (rd) begin
      exp_hi = res[63:32];
      exp_lo = res[31:0];
      @(negedge clk);
      div_req_i    = 1'b0;
      div_ready_i  = 1'b0;
      flush_i      = done_fl;
      div_result_i = {$urandom, $urandom};
      #1;
      check("done_whilo", 64'(whilo_o), 64'(!done_fl));
      check("done_hi", 64'(hi_o), 64'(exp_hi));
      check("done_lo", 64'(lo_o), 64'(exp_lo));
      check("done_start", 64'(div_start_o), 64'd0);
      check("done_stall", 64'(stallreq_o), 64'd0);
      check("done_annul", 64'(div_annul_o), 64'd0);
    end
    $display("div sgn=%0d a=%h b=%h lat=%0d flush_at=%0d -> hi=%h lo=%h timeout=%0d",
             sgn, a, b, lat, fl_cyc, hi_o, lo_o, exp_to);
  endtask

  initial begin
    rst          = 1'b0;
    div_req_i    = 1'b0;
    div_signed_i = 1'b0;
    op1_i        = '0;
    op2_i        = '0;
    flush_i      = 1'b0;
    div_result_i = '0;
    div_ready_i  = 1'b0;
    #12;
    check("rst_stall", 64'(stallreq_o), 64'd0);
    check("rst_start", 64'(div_start_o), 64'd0);
    check("rst_hilo", {32'(hi_o), 32'(lo_o)}, 64'd0);
    check("rst_op", {32'(div_opdata1_o), 32'(div_opdata2_o)}, 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, 5, 0, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 3, 0, 1'b0);
    run_div(1'b0, 32'd50, 32'd5, 20, 10, 1'b0);
    run_div(1'b0, 32'd9, 32'd3, 4, 0, 1'b0);
    run_div(1'b1, 32'd123, 32'd4, 6, 6, 1'b0);
    run_div(1'b0, 32'd77, 32'd0, 2, 0, 1'b0);
    run_div(1'b0, 32'd5, 32'd1, 1, 0, 1'b0);
    run_div(1'b0, 32'd1000, 32'd3, MAX_CYCLES, 0, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 7, 0, 1'b1);
    idle_cycle(1'b1, 1'b1);
    run_div(1'b0, 32'd8, 32'd2, 0, 0, 1'b0);
    idle_cycle(1'b0, 1'b0);
    run_div(1'b0, 32'd21, 32'd4, 3, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int lat, flc, gap;
      lat = $urandom_range(0, MAX_CYCLES + 5);
      if (lat > MAX_CYCLES) lat = 0;
      flc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, MAX_CYCLES) : 0;
      run_div(1'($urandom), $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
              lat, flc, 1'($urandom_range(0, 4) == 0));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle(1'b0, 1'($urandom));
    end

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    div_req_i = 1'b1;
    op1_i     = 32'd60;
    op2_i     = 32'd6;
    flush_i   = 1'b0;
    @(negedge clk);
    #1;
    check("mid_busy_start", 64'(div_start_o), 64'd1);
    div_req_i = 1'b0;
    rst       = 1'b0;
    #1;
    check("mid_rst_start", 64'(div_start_o), 64'd0);
    check("mid_rst_stall", 64'(stallreq_o), 64'd0);
    check("mid_rst_timeout", 64'(timeout_o), 64'd0);
    check("mid_rst_hilo", {32'(hi_o), 32'(lo_o)}, 64'd0);
    @(negedge clk);
    rst    = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    exp_to = 1'b0;
    run_div(1'b0, 32'd9, 32'd3, 4, 0, 1'b0);
    idle_cycle(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
